lc3_regfile_sb: RTL and testbench

//  LC-3 general-purpose register file with built-in destination/source register decode and a
//  per-register pending-write scoreboard. Sits between decode and execute/write-back.

---
 rtl/lc3_regfile_sb_pkg.sv | 18 +
 rtl/lc3_regfile_sb_dr_decode.sv | 40 ++++
 rtl/lc3_regfile_sb.sv | 95 +++++++++
 tb/tb_lc3_regfile_sb.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_regfile_sb_pkg.sv
// Shared definitions for the LC-3 register file: destination-select encoding
// and instruction field positions.
package lc3_pkg;

    typedef enum logic [1:0] {
        DR_IR   = 2'b00,
        DR_LINK = 2'b01,
        DR_OVR  = 2'b10,
        DR_RSVD = 2'b11
    } dr_sel_e;

    localparam int LINK_REG_DEF = 7;
    localparam int FIELD_W      = 3;
    localparam int DR_HI        = 11;
    localparam int SR1_HI       = 8;
    localparam int SR2_HI       = 2;

endpackage

// File: rtl/lc3_regfile_sb_dr_decode.sv
// Register index decode: destination from dr_sel, SR1 from IR[8:6] or IR[11:9],
// SR2 from IR[2:0]. IR fields are zero-extended to the index width.
module lc3_dr_decode
    import lc3_pkg::*;
#(
    parameter int ADDR_W   = 3,
    parameter int LINK_REG = LINK_REG_DEF
) (
    input  logic [15:0]       ir,
    input  logic [1:0]        dr_sel,
    input  logic [ADDR_W-1:0] dr_ovr,
    input  logic              sr1_sel,
    output logic [ADDR_W-1:0] dr_addr,
    output logic [ADDR_W-1:0] sr1_addr,
    output logic [ADDR_W-1:0] sr2_addr,
    output logic              illegal
);

    logic [ADDR_W-1:0] w_ir_dr;
    logic [ADDR_W-1:0] w_ir_sr1;

    assign w_ir_dr  = ADDR_W'(ir[DR_HI -: FIELD_W]);
    assign w_ir_sr1 = ADDR_W'(ir[SR1_HI -: FIELD_W]);
    assign sr2_addr = ADDR_W'(ir[SR2_HI -: FIELD_W]);

    // Stores read their data register through the SR1 port.
    assign sr1_addr = sr1_sel ? w_ir_dr : w_ir_sr1;

    always_comb begin
        dr_addr = '0;
        illegal = 1'b0;
        case (dr_sel_e'(dr_sel))
            DR_IR:   dr_addr = w_ir_dr;
            DR_LINK: dr_addr = ADDR_W'(LINK_REG);
            DR_OVR:  dr_addr = dr_ovr;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/lc3_regfile_sb.sv
// LC-3 general-purpose register file with write-back bypass and a pending-write
// scoreboard that holds issue on RAW/WAW hazards until the write-back retires.
module lc3_regfile_sb
    import lc3_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int LINK_REG = LINK_REG_DEF
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic [15:0]         ir,
    input  logic [1:0]          dr_sel,
    input  logic [ADDR_W-1:0]   dr_ovr,
    input  logic                sr1_sel,
    input  logic                issue_valid,
    input  logic                issue_we,
    output logic                issue_ready,
    output logic [ADDR_W-1:0]   dr_addr,
    output logic [DATA_W-1:0]   sr1_data,
    output logic [DATA_W-1:0]   sr2_data,
    input  logic                wb_valid,
    input  logic [ADDR_W-1:0]   wb_addr,
    input  logic [DATA_W-1:0]   wb_data,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic                wb_err
);

    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_busy;
    logic                r_wb_err;

    logic [ADDR_W-1:0]   w_sr1_addr;
    logic [ADDR_W-1:0]   w_sr2_addr;
    logic                w_illegal;
    logic                w_sr1_busy;
    logic                w_sr2_busy;
    logic                w_dr_busy;
    logic                w_issue_set;
    logic [NUM_REGS-1:0] w_busy_nxt;

    lc3_dr_decode #(
        .ADDR_W   (ADDR_W),
        .LINK_REG (LINK_REG)
    ) u_dr_decode (
        .ir       (ir),
        .dr_sel   (dr_sel),
        .dr_ovr   (dr_ovr),
        .sr1_sel  (sr1_sel),
        .dr_addr  (dr_addr),
        .sr1_addr (w_sr1_addr),
        .sr2_addr (w_sr2_addr),
        .illegal  (w_illegal)
    );

    assign sr1_data = (wb_valid && wb_addr == w_sr1_addr) ? wb_data : r_regs[w_sr1_addr];
    assign sr2_data = (wb_valid && wb_addr == w_sr2_addr) ? wb_data : r_regs[w_sr2_addr];

    // A register retiring this cycle is no longer a hazard: its value arrives via bypass.
    assign w_sr1_busy = r_busy[w_sr1_addr] && !(wb_valid && wb_addr == w_sr1_addr);
    assign w_sr2_busy = r_busy[w_sr2_addr] && !(wb_valid && wb_addr == w_sr2_addr);
    assign w_dr_busy  = r_busy[dr_addr]    && !(wb_valid && wb_addr == dr_addr);

    assign issue_ready = !w_sr1_busy && !w_sr2_busy && !(issue_we && (w_dr_busy || w_illegal));
    assign w_issue_set = issue_valid && issue_ready && issue_we;

    // Clear first, then set, so a same-edge issue to the retiring index keeps it busy.
    always_comb begin
        w_busy_nxt = r_busy;
        if (wb_valid)    w_busy_nxt[wb_addr] = 1'b0;
        if (w_issue_set) w_busy_nxt[dr_addr] = 1'b1;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
            r_busy   <= '0;
            r_wb_err <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            if (wb_valid) begin
                r_regs[wb_addr] <= wb_data;
                if (!r_busy[wb_addr]) r_wb_err <= 1'b1;
            end
        end
    end

    assign busy_vec = r_busy;
    assign wb_err   = r_wb_err;

    logic w_unused_ir;
    assign w_unused_ir = ^{ir[15:12], ir[5:3]};

endmodule

// File: tb/tb_lc3_regfile_sb.sv
// Self-checking bench for lc3_regfile_sb: decode table, directed hazard
// sequences, mid-run reset and a randomized run against a reference model.
module tb_lc3_regfile_sb;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [15:0] ir;
    logic [1:0]  dr_sel;
    logic [2:0]  dr_ovr;
    logic        sr1_sel;
    logic        issue_valid;
    logic        issue_we;
    logic        issue_ready;
    logic [2:0]  dr_addr;
    logic [15:0] sr1_data;
    logic [15:0] sr2_data;
    logic        wb_valid;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic [7:0]  busy_vec;
    logic        wb_err;

    always #5 Clk = ~Clk;

    lc3_regfile_sb dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .ir          (ir),
        .dr_sel      (dr_sel),
        .dr_ovr      (dr_ovr),
        .sr1_sel     (sr1_sel),
        .issue_valid (issue_valid),
        .issue_we    (issue_we),
        .issue_ready (issue_ready),
        .dr_addr     (dr_addr),
        .sr1_data    (sr1_data),
        .sr2_data    (sr2_data),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .busy_vec    (busy_vec),
        .wb_err      (wb_err)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural register contents, pending-write set, error flag.
    logic [15:0] m_regs [8];
    bit          m_busy [8];
    bit          m_err;

    task automatic m_reset();
        for (int i = 0; i < 8; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 0;
        end
        m_err = 0;
    endtask

    function automatic int m_dr();
        case (dr_sel)
            2'd0:    return int'(ir[11:9]);
            2'd1:    return 7;
            2'd2:    return int'(dr_ovr);
            default: return 0;
        endcase
    endfunction

    function automatic int m_sr1();
        return sr1_sel ? int'(ir[11:9]) : int'(ir[8:6]);
    endfunction

    function automatic logic [15:0] m_read(input int s);
        return (wb_valid && int'(wb_addr) == s) ? wb_data : m_regs[s];
    endfunction

    function automatic bit m_pending(input int s);
        return m_busy[s] && !(wb_valid && int'(wb_addr) == s);
    endfunction

    function automatic bit m_ready();
        if (m_pending(m_sr1()) || m_pending(int'(ir[2:0]))) return 0;
        if (issue_we && (dr_sel == 2'd3 || m_pending(m_dr()))) return 0;
        return 1;
    endfunction

    function automatic logic [7:0] m_busy_vec();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = m_busy[i];
        return v;
    endfunction

    // Compare every output against the model, then clock once and advance the model.
    task automatic cyc();
        bit fire;
        int d;
        #1;
        chk("dr_addr",     32'(dr_addr),     32'(m_dr()));
        chk("issue_ready", 32'(issue_ready), 32'(m_ready()));
        chk("sr1_data",    32'(sr1_data),    32'(m_read(m_sr1())));
        chk("sr2_data",    32'(sr2_data),    32'(m_read(int'(ir[2:0]))));
        chk("busy_vec",    32'(busy_vec),    32'(m_busy_vec()));
        chk("wb_err",      32'(wb_err),      32'(m_err));
        fire = issue_valid && issue_we && m_ready();
        d    = m_dr();
        @(posedge Clk);
        if (wb_valid) begin
            m_regs[wb_addr] = wb_data;
            if (!m_busy[wb_addr]) m_err = 1;
            m_busy[wb_addr] = 0;
        end
        if (fire) m_busy[d] = 1;
        @(negedge Clk);
    endtask

    task automatic idle();
        ir = '0; dr_sel = '0; dr_ovr = '0; sr1_sel = 0;
        issue_valid = 0; issue_we = 0;
        wb_valid = 0; wb_addr = '0; wb_data = '0;
    endtask

    typedef struct {
        logic [15:0] ir;
        logic [1:0]  sel;
        logic [2:0]  ovr;
        logic        s1sel;
        logic        we;
        logic [2:0]  exp_dr;
        logic [15:0] exp_sr1;
        logic [15:0] exp_sr2;
        logic        exp_rdy;
    } vec_t;

    vec_t tbl [7];

    initial begin
        // Registers hold 16'h1100+i when the table is applied.
        tbl[0] = '{16'h1A42, 2'd0, 3'd0, 1'b0, 1'b1, 3'd5, 16'h1101, 16'h1102, 1'b1};
        tbl[1] = '{16'h1A42, 2'd1, 3'd0, 1'b0, 1'b1, 3'd7, 16'h1101, 16'h1102, 1'b1};
        tbl[2] = '{16'h1A42, 2'd2, 3'd2, 1'b0, 1'b1, 3'd2, 16'h1101, 16'h1102, 1'b1};
        tbl[3] = '{16'h1A42, 2'd3, 3'd0, 1'b0, 1'b1, 3'd0, 16'h1101, 16'h1102, 1'b0};
        tbl[4] = '{16'h1A42, 2'd3, 3'd0, 1'b0, 1'b0, 3'd0, 16'h1101, 16'h1102, 1'b1};
        tbl[5] = '{16'h1A42, 2'd0, 3'd0, 1'b1, 1'b1, 3'd5, 16'h1105, 16'h1102, 1'b1};
        tbl[6] = '{16'h0FFF, 2'd0, 3'd0, 1'b0, 1'b1, 3'd7, 16'h1107, 16'h1107, 1'b1};

        idle();
        Reset_n = 0;
        m_reset();
        #12;
        chk("reset busy_vec", 32'(busy_vec), 32'h0);
        chk("reset wb_err",   32'(wb_err),   32'h0);
        chk("reset sr1_data", 32'(sr1_data), 32'h0);
        @(negedge Clk);
        Reset_n = 1;

        // Load R0..R7 through issue then retire.
        for (int i = 0; i < 8; i++) begin
            dr_sel = 2'd2; dr_ovr = 3'(i); issue_valid = 1; issue_we = 1;
            cyc();
            issue_valid = 0; issue_we = 0;
            wb_valid = 1; wb_addr = 3'(i); wb_data = 16'h1100 + 16'(i);
            cyc();
            wb_valid = 0;
        end
        chk("load busy_vec", 32'(busy_vec), 32'h0);

        for (int i = 0; i < 7; i++) begin
            ir = tbl[i].ir; dr_sel = tbl[i].sel; dr_ovr = tbl[i].ovr;
            sr1_sel = tbl[i].s1sel; issue_we = tbl[i].we; issue_valid = 0;
            #1;
            chk($sformatf("tbl%0d dr_addr", i),  32'(dr_addr),     32'(tbl[i].exp_dr));
            chk($sformatf("tbl%0d sr1_data", i), 32'(sr1_data),    32'(tbl[i].exp_sr1));
            chk($sformatf("tbl%0d sr2_data", i), 32'(sr2_data),    32'(tbl[i].exp_sr2));
            chk($sformatf("tbl%0d ready", i),    32'(issue_ready), 32'(tbl[i].exp_rdy));
            @(negedge Clk);
        end
        idle();

        // RAW: ADD R1 issues, then ADD R2,R1,R0 stalls until R1 retires.
        ir = 16'h1200; issue_valid = 1; issue_we = 1;
        cyc();
        chk("raw busy1", 32'(busy_vec[1]), 32'h1);
        ir = 16'h1440;
        #1 chk("raw stall", 32'(issue_ready), 32'h0);
        cyc();
        wb_valid = 1; wb_addr = 3'd1; wb_data = 16'hBEEF;
        #1;
        chk("raw release", 32'(issue_ready), 32'h1);
        chk("raw bypass",  32'(sr1_data),    32'hBEEF);
        cyc();
        issue_valid = 0; wb_addr = 3'd2; wb_data = 16'h2020;
        cyc();
        wb_valid = 0;

        // WAW on R4.
        ir = 16'h1800; issue_valid = 1; issue_we = 1;
        cyc();
        #1 chk("waw stall", 32'(issue_ready), 32'h0);
        cyc();
        issue_valid = 0; wb_valid = 1; wb_addr = 3'd4; wb_data = 16'h4444;
        #1 chk("waw release", 32'(issue_ready), 32'h1);
        cyc();
        wb_valid = 0;
        chk("waw clear", 32'(busy_vec), 32'h0);

        // Same-edge issue and retire of R6: busy stays set, data lands.
        ir = 16'h1C00; issue_valid = 1; issue_we = 1;
        cyc();
        wb_valid = 1; wb_addr = 3'd6; wb_data = 16'h6666;
        cyc();
        idle();
        ir = 16'h0180;
        #1;
        chk("simul busy6", 32'(busy_vec[6]), 32'h1);
        chk("simul data6", 32'(sr1_data),    32'h6666);
        chk("simul no err", 32'(wb_err),     32'h0);
        cyc();
        wb_valid = 1; wb_addr = 3'd6; wb_data = 16'h6667;
        cyc();
        wb_valid = 0;

        // Spurious write-back to idle R2.
        wb_valid = 1; wb_addr = 3'd2; wb_data = 16'h2222;
        cyc();
        wb_valid = 0; ir = 16'h0080;
        #1;
        chk("spur err",  32'(wb_err),   32'h1);
        chk("spur data", 32'(sr1_data), 32'h2222);
        cyc(); cyc();
        chk("spur sticky", 32'(wb_err), 32'h1);

        // Reset mid-run with R3 pending.
        ir = 16'h1600; issue_valid = 1; issue_we = 1;
        cyc();
        idle();
        ir = 16'h00C0;
        chk("pre-reset busy3", 32'(busy_vec[3]), 32'h1);
        #3 Reset_n = 0;
        #1;
        chk("mid reset busy_vec", 32'(busy_vec), 32'h0);
        chk("mid reset sr1_data", 32'(sr1_data), 32'h0);
        chk("mid reset wb_err",   32'(wb_err),   32'h0);
        m_reset();
        @(negedge Clk);
        Reset_n = 1;

        // Randomized run against the model.
        for (int n = 0; n < 400; n++) begin
            int pick;
            ir          = 16'($urandom);
            dr_sel      = 2'($urandom_range(0, 3));
            dr_ovr      = 3'($urandom);
            sr1_sel     = 1'($urandom);
            issue_valid = ($urandom_range(0, 3) != 0);
            issue_we    = ($urandom_range(0, 3) != 0);
            wb_data     = 16'($urandom);
            wb_valid    = 0;
            pick        = $urandom_range(0, 7);
            for (int k = 0; k < 8; k++) begin
                if (!wb_valid && m_busy[(pick + k) % 8] && $urandom_range(0, 2) != 0) begin
                    wb_valid = 1;
                    wb_addr  = 3'((pick + k) % 8);
                end
            end
            if (!wb_valid && $urandom_range(0, 19) == 0) begin
                wb_valid = 1;
                wb_addr  = 3'($urandom);
            end
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, limit %0d ns", 200000);
        $fatal(1, "timeout");
    end

endmodule
